cla_64bit: RTL and testbench

CLA_64BIT -- requirements
Module: cla_64bit

---
 rtl/cla_64bit.sv | 138 +++++++++++++
 tb/tb_cla_64bit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/cla_64bit.sv
// 64-bit registered hierarchical carry-lookahead adder (4-bit groups, 16-bit blocks).
// Define CLA_IN_REG_EN to register operands ahead of the core (2-cycle latency).

module cla_lcu4 (
    input  logic [3:0] g_i,
    input  logic [3:0] p_i,
    input  logic       c_i,
    output logic [3:0] c_o,
    output logic       g_o,
    output logic       p_o
);
    // c_o[k] is the carry into slice k; group G/P never depend on c_i
    assign c_o[0] = c_i;
    assign c_o[1] = g_i[0]
                  | (p_i[0] & c_i);
    assign c_o[2] = g_i[1]
                  | (p_i[1] & g_i[0])
                  | (p_i[1] & p_i[0] & c_i);
    assign c_o[3] = g_i[2]
                  | (p_i[2] & g_i[1])
                  | (p_i[2] & p_i[1] & g_i[0])
                  | (p_i[2] & p_i[1] & p_i[0] & c_i);
    assign g_o    = g_i[3]
                  | (p_i[3] & g_i[2])
                  | (p_i[3] & p_i[2] & g_i[1])
                  | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
    assign p_o    = &p_i;
endmodule

module cla_64bit (
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout,
    input  logic        CLK,
    input  logic        reset
);
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        op_c;

`ifdef CLA_IN_REG_EN
    logic [63:0] a_q;
    logic [63:0] b_q;
    logic        cin_q;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else begin
            a_q   <= in_a;
            b_q   <= in_b;
            cin_q <= cin;
        end
    end

    assign op_a = a_q;
    assign op_b = b_q;
    assign op_c = cin_q;
`else
    assign op_a = in_a;
    assign op_b = in_b;
    assign op_c = cin;
`endif

    logic [63:0] g;
    logic [63:0] p;
    logic [63:0] c;
    logic [15:0] grp_g;
    logic [15:0] grp_p;
    logic [15:0] grp_c;
    logic [3:0]  blk_g;
    logic [3:0]  blk_p;
    logic [3:0]  blk_c;
    logic        top_g;
    logic        top_p;

    assign g = op_a & op_b;
    assign p = op_a ^ op_b;

    // Level 1: bit carries inside each 4-bit group
    for (genvar k = 0; k < 16; k++) begin : g_grp
        cla_lcu4 u_grp (
            .g_i (g[4*k +: 4]),
            .p_i (p[4*k +: 4]),
            .c_i (grp_c[k]),
            .c_o (c[4*k +: 4]),
            .g_o (grp_g[k]),
            .p_o (grp_p[k])
        );
    end

    // Level 2: group carries inside each 16-bit block
    for (genvar j = 0; j < 4; j++) begin : g_blk
        cla_lcu4 u_blk (
            .g_i (grp_g[4*j +: 4]),
            .p_i (grp_p[4*j +: 4]),
            .c_i (blk_c[j]),
            .c_o (grp_c[4*j +: 4]),
            .g_o (blk_g[j]),
            .p_o (blk_p[j])
        );
    end

    // Level 3: block carries and final carry-out
    cla_lcu4 u_top (
        .g_i (blk_g),
        .p_i (blk_p),
        .c_i (op_c),
        .c_o (blk_c),
        .g_o (top_g),
        .p_o (top_p)
    );

    logic [63:0] sum_d;
    logic [63:0] sum_q;
    logic        cout_d;
    logic        cout_q;

    assign sum_d  = p ^ c;
    assign cout_d = top_g | (top_p & op_c);

    always_ff @(posedge CLK) begin
        if (!reset) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_cla_64bit.sv
// Self-checking bench for cla_64bit: directed corner vectors plus a
// back-to-back random stream with a mid-stream reset pulse.

module tb_cla_64bit;
`ifdef CLA_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        CLK;
    logic        reset;

    int n_checks = 0;
    int n_fail   = 0;

    logic [64:0] pipe [LAT];

    cla_64bit dut (
        .in_a  (in_a),
        .in_b  (in_b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .CLK   (CLK),
        .reset (reset)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [64:0] got,
                         input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge; the reference delay line tracks the DUT pipeline.
    task automatic tick();
        @(posedge CLK);
        if (!reset) begin
            for (int i = 0; i < LAT; i++) pipe[i] = '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = {1'b0, in_a} + {1'b0, in_b} + {64'd0, cin};
        end
        #1;
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b,
                         input logic c);
        in_a = a;
        in_b = b;
        cin  = c;
    endtask

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        c;
        logic [64:0] exp;
        string       tag;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{64'd5, 64'd7, 1'b0, 65'h0_0000_0000_0000_000C, "five_plus_seven"};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1,
                    65'h1_0000_0000_0000_0000, "ones_plus_zero_cin"};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                    65'h1_FFFF_FFFF_FFFF_FFFF, "ones_plus_ones_cin"};
        vecs[3] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0,
                    65'h0_0000_0000_0001_0000, "blk16_boundary"};
        vecs[4] = '{64'd0, 64'd0, 1'b0, 65'h0, "zero"};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                    65'h1_0000_0000_0000_0000, "msb_carry"};
        vecs[6] = '{64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 1'b0,
                    65'h0_FFFF_FFFF_FFFF_FFFF, "all_propagate"};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                    65'h1_FFFF_FFFF_FFFF_FFFE, "ones_plus_ones"};
        vecs[8] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0,
                    65'h0_0000_0001_0000_0000, "blk32_boundary"};
        vecs[9] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1,
                    65'h0_2345_6789_ABCD_F002, "mixed_pattern"};

        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        reset = 1'b1;
        drive(64'hDEAD_BEEF_0000_1234, 64'h1111_2222_3333_4444, 1'b1);
        tick();

        // Single-edge reset with live operands must still clear outputs
        reset = 1'b0;
        tick();
        check("reset_state", {cout, sum}, 65'h0);
        reset = 1'b1;

        drive(64'd5, 64'd7, 1'b0);
        for (int i = 0; i < LAT - 1; i++) begin
            tick();
            check("pre_latency_zero", {cout, sum}, 65'h0);
        end
        tick();
        check("first_result", {cout, sum}, 65'h0_0000_0000_0000_000C);

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].c);
            for (int k = 0; k < LAT; k++) tick();
            check(vecs[i].tag, {cout, sum}, vecs[i].exp);
            tick();
            check({vecs[i].tag, "_hold"}, {cout, sum}, vecs[i].exp);
        end

        // Back-to-back stream: new operands every cycle
        for (int n = 0; n < 1000; n++) begin
            drive({$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 1)));
            reset = (n == 500) ? 1'b0 : 1'b1;
            tick();
            if (n == 500)
                check("midstream_reset", {cout, sum}, 65'h0);
            check("stream", {cout, sum}, pipe[LAT-1]);
        end
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
